// File: rtl/risc_pkg.sv
// Shared definitions for the RISC core and its boot loader.
package risc_pkg;

  localparam int unsigned ADDR_W_DEF = 10;

  localparam logic [5:0] OP_HLT  = 6'b111111;
  localparam logic [5:0] OP_LW   = 6'b001000;
  localparam logic [5:0] OP_SW   = 6'b001001;
  localparam logic [5:0] OP_ADDI = 6'b001010;
  localparam logic [5:0] OP_ADD  = 6'b000011;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_HDR,
    LD_DATA,
    LD_CSUM,
    LD_DONE,
    LD_ERR
  } ld_state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Shifts bytes into a big-endian 32-bit word; word_done_o flags the 4th byte
// combinationally, with word_o already holding the complete word in that cycle.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  assign word_o      = {shift_q, byte_i};
  assign word_done_o = byte_vld_i && (cnt_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clr_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_vld_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a BASE/COUNT/payload/CSUM byte frame, writes words to
// core memory, and releases the core only after a verified image.
module program_loader
  import risc_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              release_en,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_hold,
  output logic              core_start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       wc_q, wc_d;
  logic [7:0]        csum_q, csum_d;
  logic              rel_q, rel_d;
  logic              hold_q, hold_d;
  logic              cstart_q, cstart_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic        accept, pk_clr, pk_vld, word_done, hdr_bad;
  logic [31:0] word;
  logic [16:0] hdr_end;

  assign in_ready = (state_q == LD_HDR) || (state_q == LD_DATA) || (state_q == LD_CSUM);
  assign busy     = in_ready;
  assign accept   = in_valid && in_ready;
  assign pk_vld   = accept && ((state_q == LD_HDR) || (state_q == LD_DATA));

  byte_word_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (pk_clr),
    .byte_vld_i  (pk_vld),
    .byte_i      (in_data),
    .word_o      (word),
    .word_done_o (word_done)
  );

  // Header word is {BASE, COUNT}; the end bound is checked at 17 bits so it cannot wrap.
  assign hdr_end = {1'b0, word[31:16]} + {1'b0, word[15:0]};
  assign hdr_bad = (word[15:0] == 16'd0) || (hdr_end > (17'd1 << ADDR_W));

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    count_d  = count_q;
    wc_d     = wc_q;
    csum_d   = csum_q;
    rel_d    = rel_q;
    hold_d   = hold_q;
    cstart_d = 1'b0;
    done_d   = done_q;
    err_d    = err_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pk_clr   = 1'b0;
    case (state_q)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start) begin
          state_d = LD_HDR;
          done_d  = 1'b0;
          err_d   = 1'b0;
          wc_d    = '0;
          csum_d  = '0;
          rel_d   = release_en;
          hold_d  = 1'b1;
          pk_clr  = 1'b1;
        end
      end
      LD_HDR: begin
        if (word_done) begin
          base_d  = word[16 +: ADDR_W];
          count_d = word[15:0];
          if (hdr_bad) begin
            state_d = LD_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = LD_DATA;
          end
        end
      end
      LD_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ in_data;
          if (word_done) begin
            we_d    = 1'b1;
            addr_d  = base_q + wc_q[ADDR_W-1:0];
            wdata_d = word;
            wc_d    = wc_q + 16'd1;
            if (wc_q + 16'd1 == count_q) state_d = LD_CSUM;
          end
        end
      end
      LD_CSUM: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d = LD_DONE;
            done_d  = 1'b1;
            if (rel_q) begin
              cstart_d = 1'b1;
              hold_d   = 1'b0;
            end
          end else begin
            state_d = LD_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LD_IDLE;
      base_q   <= '0;
      count_q  <= '0;
      wc_q     <= '0;
      csum_q   <= '0;
      rel_q    <= 1'b0;
      hold_q   <= 1'b1;
      cstart_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      count_q  <= count_d;
      wc_q     <= wc_d;
      csum_q   <= csum_d;
      rel_q    <= rel_d;
      hold_q   <= hold_d;
      cstart_q <= cstart_d;
      done_q   <= done_d;
      err_q    <= err_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign core_hold  = hold_q;
  assign core_start = cstart_q;
  assign done       = done_q;
  assign error      = err_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frame loads, header/checksum errors,
// input gaps and asynchronous reset in mid-frame.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        release_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, core_hold, core_start, busy, done, error;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] word_count;

  int ncmp = 0;
  int nfail = 0;

  // Write/pulse monitor; the directed sequence only reads these.
  int          wr_n = 0;
  int          cs_n = 0;
  logic [9:0]  wa [0:63];
  logic [31:0] wd [0:63];
  logic [31:0] prog [0:7];

  program_loader #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .release_en(release_en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .core_start(core_start), .busy(busy),
    .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_n < 64) begin
        wa[wr_n] = mem_addr;
        wd[wr_n] = mem_wdata;
      end
      wr_n = wr_n + 1;
    end
    if (core_start) cs_n = cs_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic rel);
    start = 1'b1;
    release_en = rel;
    tick(1);
    start = 1'b0;
    release_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit ok;
    int t;
    for (int g = 0; g < 6 && rnd && ($urandom_range(0, 1) == 0); g++) begin
      in_valid = 1'b0;
      tick(1);
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 200) begin
      ok = in_ready;
      tick(1);
      t++;
    end
    in_valid = 1'b0;
    if (!ok) check("handshake_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], rnd);
  endtask

  task automatic send_frame(input logic [15:0] base, input logic [15:0] cnt,
                            input logic [7:0] csum, input bit rnd);
    send_word({base, cnt}, rnd);
    for (int i = 0; i < int'(cnt); i++) send_word(prog[i], rnd);
    send_byte(csum, rnd);
  endtask

  task automatic load_program;
    prog[0] = 32'h28010078; prog[1] = 32'h0c631800;
    prog[2] = 32'h20220000; prog[3] = 32'h0c631800;
    prog[4] = 32'h2842002d; prog[5] = 32'h0c631800;
    prog[6] = 32'h24220001; prog[7] = 32'hfc000000;
  endtask

  task automatic check_program(input string tag, input int w0);
    check({tag, "_nwr"}, 32'(wr_n - w0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_addr"}, 32'(wa[w0 + i]), 32'(i));
      check({tag, "_data"}, wd[w0 + i], prog[i]);
    end
  endtask

  int w0, c0;

  initial begin
    tick(2);
    // Reset state.
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_hold", 32'(core_hold), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wc", 32'(word_count), 32'd0);
    rst_n = 1'b1;
    tick(2);
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Program load with release; XOR of payload bytes = 0x98.
    load_program();
    w0 = wr_n; c0 = cs_n;
    do_start(1'b1);
    check("p1_busy", 32'(busy), 32'd1);
    check("p1_hold_loading", 32'(core_hold), 32'd1);
    send_frame(16'h0000, 16'd8, 8'h98, 1'b0);
    tick(1);
    check_program("p1", w0);
    check("p1_wc", 32'(word_count), 32'd8);
    check("p1_done", 32'(done), 32'd1);
    check("p1_error", 32'(error), 32'd0);
    check("p1_cstart", 32'(cs_n - c0), 32'd1);
    check("p1_hold", 32'(core_hold), 32'd0);
    check("p1_in_ready", 32'(in_ready), 32'd0);
    check("p1_busy_end", 32'(busy), 32'd0);

    // Data load at 0x78 without release.
    prog[0] = 32'h00000063;
    w0 = wr_n; c0 = cs_n;
    do_start(1'b0);
    check("d_hold_reassert", 32'(core_hold), 32'd1);
    check("d_done_cleared", 32'(done), 32'd0);
    check("d_wc_cleared", 32'(word_count), 32'd0);
    send_frame(16'h0078, 16'd1, 8'h63, 1'b0);
    tick(1);
    check("d_nwr", 32'(wr_n - w0), 32'd1);
    check("d_addr", 32'(wa[w0]), 32'd120);
    check("d_data", wd[w0], 32'd99);
    check("d_done", 32'(done), 32'd1);
    check("d_cstart", 32'(cs_n - c0), 32'd0);
    check("d_hold", 32'(core_hold), 32'd1);

    // Header error: 0x3FF + 2 exceeds 1024 words.
    w0 = wr_n;
    do_start(1'b1);
    send_word({16'h03FF, 16'd2}, 1'b0);
    check("h1_in_ready", 32'(in_ready), 32'd0);
    tick(1);
    check("h1_error", 32'(error), 32'd1);
    check("h1_done", 32'(done), 32'd0);
    check("h1_nwr", 32'(wr_n - w0), 32'd0);

    // Header error: COUNT 0. Boundary 0x3FF + 1 == 1024 is legal and covered below.
    do_start(1'b1);
    send_word({16'h0000, 16'd0}, 1'b0);
    check("h0_in_ready", 32'(in_ready), 32'd0);
    tick(1);
    check("h0_error", 32'(error), 32'd1);
    check("h0_nwr", 32'(wr_n - w0), 32'd0);

    // Top-of-memory single word: 0x3FF + 1 fits exactly.
    prog[0] = 32'h01020304;
    w0 = wr_n;
    do_start(1'b0);
    send_frame(16'h03FF, 16'd1, 8'h04, 1'b0);
    tick(1);
    check("top_done", 32'(done), 32'd1);
    check("top_addr", 32'(wa[w0]), 32'h3FF);

    // Bad checksum: XOR of 12 34 56 78 is 0x08, send 0x09.
    prog[0] = 32'h12345678;
    w0 = wr_n; c0 = cs_n;
    do_start(1'b1);
    send_frame(16'h0005, 16'd1, 8'h09, 1'b0);
    tick(1);
    check("cs_nwr", 32'(wr_n - w0), 32'd1);
    check("cs_addr", 32'(wa[w0]), 32'd5);
    check("cs_data", wd[w0], 32'h12345678);
    check("cs_error", 32'(error), 32'd1);
    check("cs_done", 32'(done), 32'd0);
    check("cs_cstart", 32'(cs_n - c0), 32'd0);
    check("cs_hold", 32'(core_hold), 32'd1);

    // Same program as the first load, with random input gaps.
    load_program();
    w0 = wr_n; c0 = cs_n;
    do_start(1'b1);
    send_frame(16'h0000, 16'd8, 8'h98, 1'b1);
    tick(1);
    check_program("gap", w0);
    check("gap_wc", 32'(word_count), 32'd8);
    check("gap_done", 32'(done), 32'd1);
    check("gap_cstart", 32'(cs_n - c0), 32'd1);
    check("gap_hold", 32'(core_hold), 32'd0);

    // Reset after two payload bytes, then a clean reload.
    do_start(1'b1);
    send_word({16'h0010, 16'd1}, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    rst_n = 1'b0;
    #2;
    check("mr_in_ready", 32'(in_ready), 32'd0);
    check("mr_we", 32'(mem_we), 32'd0);
    check("mr_addr", 32'(mem_addr), 32'd0);
    check("mr_wdata", mem_wdata, 32'd0);
    check("mr_hold", 32'(core_hold), 32'd1);
    check("mr_cstart", 32'(core_start), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_error", 32'(error), 32'd0);
    check("mr_wc", 32'(word_count), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    prog[0] = 32'hDEADBEEF;
    w0 = wr_n; c0 = cs_n;
    do_start(1'b1);
    send_frame(16'h0010, 16'd1, 8'h22, 1'b0);
    tick(1);
    check("mr2_nwr", 32'(wr_n - w0), 32'd1);
    check("mr2_addr", 32'(wa[w0]), 32'd16);
    check("mr2_data", wd[w0], 32'hDEADBEEF);
    check("mr2_done", 32'(done), 32'd1);
    check("mr2_cstart", 32'(cs_n - c0), 32'd1);
    check("mr2_hold", 32'(core_hold), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
